// File: rtl/forwarding_writeback_unit.sv
// MEM/WB pipeline slots, register_file write port, operand forwarding and load-use stall.
// Optional HAZ_STATS_EN macro adds a saturating 16-bit stall counter output (stall_cnt).
module forwarding_writeback_unit #(
  parameter int DW     = 32,
  parameter int AW     = 4,
  parameter int PC_REG = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          ex_rf_en,
  input  logic          ex_load,
  input  logic [AW-1:0] ex_rd,
  input  logic [DW-1:0] ex_alu,
  input  logic [DW-1:0] mem_data,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] rc,
  input  logic [DW-1:0] pa,
  input  logic [DW-1:0] pb,
  input  logic [DW-1:0] pc,
  output logic [DW-1:0] opa,
  output logic [DW-1:0] opb,
  output logic [DW-1:0] opc,
  output logic [DW-1:0] pw,
  output logic [AW-1:0] rw,
  output logic          e,
  output logic          stall
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam logic [AW-1:0] PcIdx = AW'(PC_REG);

  logic          mem_v;
  logic          mem_load;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_val;
  logic          wb_v;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_val;
  logic [DW-1:0] mem_result;

  // A load's value only exists once memory answers during its MEM slot.
  assign mem_result = mem_load ? mem_data : mem_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_v    <= 1'b0;
      mem_load <= 1'b0;
      mem_rd   <= '0;
      mem_val  <= '0;
      wb_v     <= 1'b0;
      wb_rd    <= '0;
      wb_val   <= '0;
    end else if (!hold) begin
      mem_v    <= ex_rf_en & ~stall;
      mem_load <= ex_load & ~stall;
      mem_rd   <= ex_rd;
      mem_val  <= ex_alu;
      wb_v     <= mem_v;
      wb_rd    <= mem_rd;
      wb_val   <= mem_result;
    end
  end

  // The younger producer in MEM shadows an older one in WB; the PC register is never bypassed.
  function automatic logic [DW-1:0] fwd(
    input logic [AW-1:0] r,
    input logic [DW-1:0] port,
    input logic          mv,
    input logic [AW-1:0] mrd,
    input logic [DW-1:0] mres,
    input logic          wv,
    input logic [AW-1:0] wrd,
    input logic [DW-1:0] wval
  );
    if (r == PcIdx)             return port;
    else if (mv && (mrd == r))  return mres;
    else if (wv && (wrd == r))  return wval;
    else                        return port;
  endfunction

  assign opa = fwd(ra, pa, mem_v, mem_rd, mem_result, wb_v, wb_rd, wb_val);
  assign opb = fwd(rb, pb, mem_v, mem_rd, mem_result, wb_v, wb_rd, wb_val);
  assign opc = fwd(rc, pc, mem_v, mem_rd, mem_result, wb_v, wb_rd, wb_val);

  assign stall = ex_rf_en & ex_load & (ex_rd != PcIdx) &
                 ((ex_rd == ra) | (ex_rd == rb) | (ex_rd == rc));

  assign pw = wb_val;
  assign rw = wb_rd;
  assign e  = wb_v & ~hold;

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && !hold && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_forwarding_writeback_unit.sv
// Scoreboard bench: stimulus pushes per-cycle expectations and expected writes, a negedge monitor pops and compares.
// The reference keeps architectural register state plus a list of in-flight results.
module tb_forwarding_writeback_unit;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int PCR = 15;

  typedef struct {
    logic          v;
    logic          load;
    logic [AW-1:0] rd;
    logic [DW-1:0] val;
  } slot_t;

  typedef struct {
    logic          stall;
    logic          e;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [DW-1:0] opc;
  } exp_t;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] val;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hold = 1'b0;
  logic          ex_rf_en = 1'b0;
  logic          ex_load = 1'b0;
  logic [AW-1:0] ex_rd = '0;
  logic [DW-1:0] ex_alu = '0;
  logic [DW-1:0] mem_data = '0;
  logic [AW-1:0] ra = '0, rb = '0, rc = '0;
  logic [DW-1:0] pa = '0, pb = '0, pc = '0;
  logic [DW-1:0] opa, opb, opc, pw;
  logic [AW-1:0] rw;
  logic          e, stall;
`ifdef HAZ_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  exp_t          exp_q[$];
  wr_t           wr_q[$];
  slot_t         pipe[2];
  logic [DW-1:0] committed[16];
  logic [DW-1:0] rf[16];
  int            errors = 0;
  int            checks = 0;
  int            model_stalls = 0;

  always #5 clk = ~clk;

  forwarding_writeback_unit #(.DW(DW), .AW(AW), .PC_REG(PCR)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .ex_rf_en(ex_rf_en), .ex_load(ex_load), .ex_rd(ex_rd), .ex_alu(ex_alu),
    .mem_data(mem_data),
    .ra(ra), .rb(rb), .rc(rc), .pa(pa), .pb(pb), .pc(pc),
    .opa(opa), .opb(opb), .opc(opc),
    .pw(pw), .rw(rw), .e(e), .stall(stall)
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // The register file of the environment; it ignores writes while reset is asserted.
  always @(posedge clk) begin
    if (e && !rst) rf[rw] <= pw;
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Architectural value a reader should observe: newest in-flight producer, else committed state.
  function automatic logic [DW-1:0] expectOp(input logic [AW-1:0] r);
    if (r == AW'(PCR)) return committed[r];
    for (int i = 0; i < 2; i++)
      if (pipe[i].v && pipe[i].rd == r) return pipe[i].val;
    return committed[r];
  endfunction

  task automatic applyStimulus(input logic r_st, input logic h, input logic en, input logic ld,
                               input logic [AW-1:0] rd, input logic [DW-1:0] alu,
                               input logic [DW-1:0] lval,
                               input logic [AW-1:0] a, input logic [AW-1:0] b,
                               input logic [AW-1:0] c);
    exp_t  x;
    slot_t s;
    wr_t   w;
    rst = r_st; hold = h; ex_rf_en = en; ex_load = ld; ex_rd = rd; ex_alu = alu;
    mem_data = (pipe[0].v && pipe[0].load) ? pipe[0].val : $urandom();
    ra = a; rb = b; rc = c;
    pa = rf[a]; pb = rf[b]; pc = rf[c];
    x.stall = en && ld && (rd != AW'(PCR)) && (rd == a || rd == b || rd == c);
    x.e     = pipe[1].v && !h;
    x.opa   = expectOp(a);
    x.opb   = expectOp(b);
    x.opc   = expectOp(c);
    exp_q.push_back(x);
    if (r_st) wr_q.delete();
    @(posedge clk);
    if (r_st) begin
      pipe[0] = '{v: 1'b0, load: 1'b0, rd: '0, val: '0};
      pipe[1] = pipe[0];
      model_stalls = 0;
    end else if (!h) begin
      if (x.stall && model_stalls < 65535) model_stalls++;
      if (pipe[1].v) committed[pipe[1].rd] = pipe[1].val;
      pipe[1] = pipe[0];
      s.v    = en && !x.stall;
      s.load = ld;
      s.rd   = rd;
      s.val  = ld ? lval : alu;
      pipe[0] = s;
      if (s.v) begin
        w.rd = rd; w.val = s.val;
        wr_q.push_back(w);
      end
    end
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, a, b, c);
  endtask

  function automatic logic [AW-1:0] pickReg();
    logic [AW-1:0] pool[4];
    pool[0] = 3; pool[1] = 5; pool[2] = 10; pool[3] = 15;
    if ($urandom_range(9) < 7) return pool[$urandom_range(3)];
    return AW'($urandom_range(15));
  endfunction

  // Monitor: one expectation per cycle, one expected write per observed write strobe.
  initial begin
    exp_t x;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checkOutput("stall", {31'd0, stall}, {31'd0, x.stall});
        checkOutput("e", {31'd0, e}, {31'd0, x.e});
        checkOutput("opa", opa, x.opa);
        checkOutput("opb", opb, x.opb);
        checkOutput("opc", opc, x.opc);
        if (e === 1'b1 && !rst) begin
          if (wr_q.size() == 0) begin
            checkOutput("write_unexpected", {28'd0, rw}, 32'hFFFF_FFFF);
          end else begin
            w = wr_q.pop_front();
            checkOutput("rw", {28'd0, rw}, {28'd0, w.rd});
            checkOutput("pw", pw, w.val);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      committed[i] = $urandom();
      rf[i] = committed[i];
    end
    pipe[0] = '{v: 1'b0, load: 1'b0, rd: '0, val: '0};
    pipe[1] = pipe[0];
    @(posedge clk);
    #1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 5, 5, 5);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 7, 15, 2);

    applyStimulus(0, 0, 1, 0, 5, 32'hAABBCCDD, 0, 0, 1, 2);
    idle(5, 1, 2);
    idle(5, 1, 2);
    idle(5, 1, 2);

    applyStimulus(0, 0, 1, 0, 10, 32'h11223344, 0, 0, 10, 0);
    applyStimulus(0, 0, 1, 0, 10, 32'h55667788, 0, 0, 10, 0);
    idle(0, 10, 0);
    idle(0, 10, 0);
    idle(0, 10, 0);

    applyStimulus(0, 0, 1, 1, 3, 32'h0, 32'hDEADBEEF, 0, 0, 3);
    applyStimulus(0, 0, 1, 1, 3, 32'h0, 32'hDEADBEEF, 0, 0, 1);
    idle(0, 0, 3);
    idle(0, 0, 3);
    idle(0, 0, 3);

    applyStimulus(0, 0, 1, 0, 15, 32'hFFFFFFFF, 0, 15, 0, 0);
    idle(15, 0, 0);
    idle(15, 0, 0);
    idle(15, 0, 0);

    applyStimulus(0, 0, 1, 0, 7, 32'h0BADF00D, 0, 7, 7, 7);
    idle(7, 0, 0);
    applyStimulus(0, 1, 1, 0, 8, 32'h12345678, 0, 7, 8, 0);
    applyStimulus(0, 1, 1, 1, 8, 32'h12345678, 32'h1, 7, 8, 0);
    applyStimulus(0, 1, 0, 0, 8, 32'h12345678, 0, 7, 8, 0);
    idle(7, 8, 0);
    idle(7, 8, 0);

    applyStimulus(0, 0, 1, 1, 4, 32'h0, 32'hCAFEF00D, 4, 0, 0);
    applyStimulus(0, 1, 1, 1, 4, 32'h0, 32'hCAFEF00D, 4, 0, 0);
    idle(4, 0, 0);

    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(99) == 0, $urandom_range(7) == 0,
                    $urandom_range(3) != 0, $urandom_range(2) == 0,
                    pickReg(), $urandom(), $urandom(),
                    pickReg(), pickReg(), pickReg());
    end

    idle(0, 0, 0);
    idle(0, 0, 0);
    idle(0, 0, 0);
    @(negedge clk);
    #1;
    checkOutput("write_drain", wr_q.size(), 0);
`ifdef HAZ_STATS_EN
    checkOutput("stall_cnt", {16'd0, stall_cnt}, model_stalls);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
